switch_ctrl_nq: RTL and testbench

Parametrised N-queue inflow switch controller for the QSFP receive buffer path. It steers incoming data into one of NUM_Q RAM queues in round-robin order and tracks which filled queues are still committing to RAM. Once a queue's inflow is fully committed, it launches that queue's RAM reader, strictly in fill order. It sits between the QSFP inflow writers and the per-queue RAM readers; with NUM_Q=2 its behaviour matches the existing two-queue ping-pong controller.

---
 rtl/switch_ctrl_nq_if.sv | 35 +++
 rtl/switch_ctrl_nq.sv | 95 +++++++++
 tb/tb_switch_ctrl_nq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/switch_ctrl_nq_if.sv
// Signal bundle between the QSFP inflow side, the RAM readers and switch_ctrl_nq.
// The master modport is the environment side; the slave modport is the controller.
interface switch_ctrl_nq_if #(
    parameter int NUM_Q = 4
);
    localparam int QW = $clog2(NUM_Q);

    logic [NUM_Q-1:0] has_data;
    logic [NUM_Q-1:0] inflow_done;
    logic [NUM_Q-1:0] ram_reader_idle;
    logic [QW-1:0]    inflow_q;
    logic [NUM_Q-1:0] ram_reader_start;
    logic [QW:0]      pending_count;
    logic             stall;

    modport master (
        output has_data,
        output inflow_done,
        output ram_reader_idle,
        input  inflow_q,
        input  ram_reader_start,
        input  pending_count,
        input  stall
    );

    modport slave (
        input  has_data,
        input  inflow_done,
        input  ram_reader_idle,
        output inflow_q,
        output ram_reader_start,
        output pending_count,
        output stall
    );
endinterface

// File: rtl/switch_ctrl_nq.sv
// N-queue inflow switch controller: steers inflow round-robin across NUM_Q
// RAM queues and launches each queue's RAM reader in fill order once its
// inflow has been committed.
module switch_ctrl_nq #(
    parameter int NUM_Q = 4
) (
    input  logic            clk,
    input  logic            reset,
    switch_ctrl_nq_if.slave bus
);
    localparam int QW = $clog2(NUM_Q);

    logic [QW-1:0]    inflow_q_r;
    logic [QW-1:0]    drain_ptr;
    logic [NUM_Q-1:0] pending;
    logic [NUM_Q-1:0] busy;
    logic [QW:0]      pending_count_r;
    logic             stall_r;
    logic [NUM_Q-1:0] start_r;

    logic [QW-1:0]    next_q;
    logic [QW-1:0]    drain_next;
    logic [NUM_Q-1:0] free;
    logic             do_switch;
    logic             do_start;
    logic [QW-1:0]    inflow_q_n;
    logic [QW-1:0]    drain_ptr_n;
    logic [NUM_Q-1:0] pending_n;
    logic [NUM_Q-1:0] busy_n;
    logic [QW:0]      pending_count_n;
    logic             stall_n;
    logic [NUM_Q-1:0] start_n;

    assign bus.inflow_q         = inflow_q_r;
    assign bus.ram_reader_start = start_r;
    assign bus.pending_count    = pending_count_r;
    assign bus.stall            = stall_r;

    // Switch/start decisions and the next value of every tracking register.
    always_comb begin
        next_q     = (inflow_q_r == QW'(NUM_Q - 1)) ? '0 : inflow_q_r + QW'(1);
        drain_next = (drain_ptr  == QW'(NUM_Q - 1)) ? '0 : drain_ptr  + QW'(1);
        free       = bus.ram_reader_idle & ~busy & ~pending;
        do_switch  = bus.has_data[inflow_q_r] & free[next_q];
        do_start   = pending[drain_ptr] & bus.inflow_done[drain_ptr];

        inflow_q_n      = inflow_q_r;
        drain_ptr_n     = drain_ptr;
        pending_n       = pending;
        busy_n          = busy & bus.ram_reader_idle;
        pending_count_n = pending_count_r;
        start_n         = '0;
        stall_n         = bus.has_data[inflow_q_r] & ~free[next_q];

        // drain_ptr never equals inflow_q while anything is pending, so the
        // set and clear below always touch different bits.
        if (do_switch) begin
            pending_n[inflow_q_r] = 1'b1;
            inflow_q_n            = next_q;
        end
        if (do_start) begin
            pending_n[drain_ptr] = 1'b0;
            busy_n[drain_ptr]    = 1'b1;
            start_n[drain_ptr]   = 1'b1;
            drain_ptr_n          = drain_next;
        end

        if (do_switch && !do_start) begin
            pending_count_n = pending_count_r + (QW+1)'(1);
        end else if (!do_switch && do_start) begin
            pending_count_n = pending_count_r - (QW+1)'(1);
        end
    end

    // State and registered outputs; reset drops all tracking and any strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflow_q_r      <= '0;
            drain_ptr       <= '0;
            pending         <= '0;
            busy            <= '0;
            pending_count_r <= '0;
            stall_r         <= 1'b0;
            start_r         <= '0;
        end else begin
            inflow_q_r      <= inflow_q_n;
            drain_ptr       <= drain_ptr_n;
            pending         <= pending_n;
            busy            <= busy_n;
            pending_count_r <= pending_count_n;
            stall_r         <= stall_n;
            start_r         <= start_n;
        end
    end
endmodule

// File: tb/tb_switch_ctrl_nq.sv
// Self-checking bench for switch_ctrl_nq: directed scenarios followed by
// random stimulus, all checked against a fill-order queue model.
module tb_switch_ctrl_nq;
    localparam int NUM_Q = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    switch_ctrl_nq_if #(.NUM_Q(NUM_Q)) bus ();

    switch_ctrl_nq #(.NUM_Q(NUM_Q)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: queues awaiting their reader start, in fill order.
    int fifo[$];
    int cur;
    bit wait_ack[NUM_Q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_fifo(input int q);
        foreach (fifo[i]) if (fifo[i] == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_free(input int q);
        return bus.ram_reader_idle[q] && !wait_ack[q] && !in_fifo(q);
    endfunction

    task automatic model_reset();
        fifo.delete();
        cur = 0;
        for (int q = 0; q < NUM_Q; q++) wait_ack[q] = 1'b0;
    endtask

    // Advance one clock with the inputs currently driven and check all outputs.
    task automatic step();
        int nxt;
        int head;
        bit sw;
        bit st;
        bit exp_stall;
        logic [NUM_Q-1:0] exp_start;
        nxt       = (cur + 1) % NUM_Q;
        sw        = bus.has_data[cur] && is_free(nxt);
        exp_stall = bus.has_data[cur] && !is_free(nxt);
        st        = (fifo.size() > 0) && bus.inflow_done[fifo[0]];
        exp_start = '0;
        for (int q = 0; q < NUM_Q; q++) if (!bus.ram_reader_idle[q]) wait_ack[q] = 1'b0;
        if (st) begin
            head = fifo.pop_front();
            exp_start[head] = 1'b1;
            wait_ack[head]  = 1'b1;
        end
        if (sw) begin
            fifo.push_back(cur);
            cur = nxt;
        end
        @(posedge clk);
        #1;
        chk("inflow_q", 32'(bus.inflow_q), 32'(cur));
        chk("ram_reader_start", 32'(bus.ram_reader_start), 32'(exp_start));
        chk("pending_count", 32'(bus.pending_count), 32'(fifo.size()));
        chk("stall", 32'(bus.stall), 32'(exp_stall));
        chk("start_onehot", 32'($countones(bus.ram_reader_start) <= 1), 32'd1);
    endtask

    // Assert reset away from the clock edge; outputs must clear at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_inflow_q", 32'(bus.inflow_q), 32'd0);
        chk("rst_start", 32'(bus.ram_reader_start), 32'd0);
        chk("rst_pending_count", 32'(bus.pending_count), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_start", 32'(bus.ram_reader_start), 32'd0);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [NUM_Q-1:0] hd, input logic [NUM_Q-1:0] dn,
                         input logic [NUM_Q-1:0] idl);
        bus.has_data        = hd;
        bus.inflow_done     = dn;
        bus.ram_reader_idle = idl;
    endtask

    initial begin
        model_reset();

        // Reset with every input high, then the first switch.
        drive('1, '1, '1);
        do_reset();
        drive(4'b0001, 4'b0000, 4'b1111);
        step();
        chk("first_switch_q", 32'(bus.inflow_q), 32'd1);
        chk("first_switch_cnt", 32'(bus.pending_count), 32'd1);

        // In-order start: q0..q2 filled, completions arrive out of order.
        drive(4'b0010, 4'b0000, 4'b1111); step();
        drive(4'b0100, 4'b0000, 4'b1111); step();
        drive(4'b0000, 4'b0100, 4'b1111); step();
        chk("order_no_early_start", 32'(bus.ram_reader_start), 32'd0);
        drive(4'b0000, 4'b0101, 4'b1111); step();
        chk("order_start0", 32'(bus.ram_reader_start), 32'b0001);
        drive(4'b0000, 4'b0100, 4'b1111); step();
        chk("order_strobe_1cyc", 32'(bus.ram_reader_start), 32'd0);
        step();
        drive(4'b0000, 4'b0110, 4'b1111); step();
        chk("order_start1", 32'(bus.ram_reader_start), 32'b0010);
        step();
        chk("order_start2", 32'(bus.ram_reader_start), 32'b0100);
        step();
        chk("order_done_cnt", 32'(bus.pending_count), 32'd0);

        // Full/stall with wrap once reader 0 cycles through busy.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b1111); step();
        drive(4'b0010, 4'b0000, 4'b1111); step();
        drive(4'b0100, 4'b0000, 4'b1111); step();
        drive(4'b1000, 4'b0000, 4'b1111); step();
        chk("full_stall", 32'(bus.stall), 32'd1);
        chk("full_cnt", 32'(bus.pending_count), 32'd3);
        chk("full_q", 32'(bus.inflow_q), 32'd3);
        drive(4'b1000, 4'b0001, 4'b1111); step();
        chk("full_start0", 32'(bus.ram_reader_start), 32'b0001);
        drive(4'b1000, 4'b0000, 4'b1111); step();
        chk("full_busy_hold", 32'(bus.inflow_q), 32'd3);
        drive(4'b1000, 4'b0000, 4'b1110); step();
        drive(4'b1000, 4'b0000, 4'b1111); step();
        chk("full_wrap_q", 32'(bus.inflow_q), 32'd0);
        chk("full_wrap_stall", 32'(bus.stall), 32'd0);

        // Busy guard: q1 started but its reader stays idle for a while.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b1111); step();
        drive(4'b0010, 4'b0000, 4'b1111); step();
        drive(4'b0000, 4'b0011, 4'b1111); step();
        step();
        chk("guard_start1", 32'(bus.ram_reader_start), 32'b0010);
        drive(4'b0100, 4'b0000, 4'b1111); step();
        drive(4'b1000, 4'b0000, 4'b1111); step();
        drive(4'b1000, 4'b0000, 4'b1110); step();
        drive(4'b1000, 4'b0000, 4'b1111); step();
        chk("guard_at_q0", 32'(bus.inflow_q), 32'd0);
        drive(4'b0001, 4'b0000, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("guard_blocked", 32'(bus.inflow_q), 32'd0);
        end
        drive(4'b0001, 4'b0000, 4'b1101); step();
        drive(4'b0001, 4'b0000, 4'b1111); step();
        chk("guard_released", 32'(bus.inflow_q), 32'd1);

        // Simultaneous switch and start.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b1111); step();
        drive(4'b0010, 4'b0001, 4'b1111); step();
        chk("simul_start", 32'(bus.ram_reader_start), 32'b0001);
        chk("simul_q", 32'(bus.inflow_q), 32'd2);
        chk("simul_cnt", 32'(bus.pending_count), 32'd1);

        // Reset while a start strobe is on the outputs, two queues pending.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b1111); step();
        drive(4'b0010, 4'b0000, 4'b1111); step();
        drive(4'b0000, 4'b0001, 4'b1111); step();
        chk("midrst_strobe", 32'(bus.ram_reader_start), 32'b0001);
        do_reset();
        drive(4'b0000, 4'b1111, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_start", 32'(bus.ram_reader_start), 32'd0);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            drive(NUM_Q'($urandom), NUM_Q'($urandom & $urandom),
                  NUM_Q'(~($urandom & $urandom)));
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
